// File: rtl/axis_adc_decimator.sv
// Boxcar decimator for the SPI ADC AXI-Stream word stream: averages 2^k samples per output word.
// Optional status byte {overrun, 3'b0, k} enabled by defining AXIS_ADC_DECIM_STATUS_EN.
module axis_adc_decimator #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int MAX_LOG2     = 8,
  parameter int PACKET_LEN   = 256
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic [3:0]            decim_log2,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int ACC_W = SAMPLE_WIDTH + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam int PKT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam int LOW_W = DATA_WIDTH - SAMPLE_WIDTH;
  localparam logic [3:0] MAX_K = 4'(MAX_LOG2);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PACKET_LEN - 1);

  logic signed [SAMPLE_WIDTH-1:0] sample_s;
  logic signed [ACC_W-1:0]        acc_r;
  logic signed [ACC_W-1:0]        sum_s;
  logic signed [ACC_W-1:0]        avg_wide_s;
  logic [CNT_W-1:0]               count_r;
  logic [CNT_W-1:0]               win_last_s;
  logic [3:0]                     k_r;
  logic [3:0]                     k_req_s;
  logic [3:0]                     k_s;
  logic                           accept_s;
  logic                           last_s;
  logic                           load_s;
  logic                           out_fire_s;
  logic [PKT_W-1:0]               pkt_r;
  logic [PKT_W-1:0]               pkt_next_s;
  logic [PKT_W-1:0]               load_idx_s;
  logic [LOW_W-1:0]               status_s;
  logic [DATA_WIDTH-1:0]          tdata_r;
  logic                           tvalid_r;
  logic                           tlast_r;
  logic                           unused_bits_s;

  assign s_axis_tready = ~areset & (~enable | ~tvalid_r | m_axis_tready);
  assign accept_s      = enable & s_axis_tvalid & s_axis_tready;
  assign out_fire_s    = tvalid_r & m_axis_tready;
  assign sample_s      = s_axis_tdata[DATA_WIDTH-1 -: SAMPLE_WIDTH];
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;
  assign unused_bits_s = ^{s_axis_tdata[LOW_W-1:0], avg_wide_s[ACC_W-1:SAMPLE_WIDTH]};

  // Window length selection, running sum, average and packet position of the next loaded word
  always_comb begin
    if (decim_log2 > MAX_K) begin
      k_req_s = MAX_K;
    end else begin
      k_req_s = decim_log2;
    end
    // The window length is frozen by its first sample; later decim_log2 changes wait for the next window.
    if (count_r == '0) begin
      k_s = k_req_s;
    end else begin
      k_s = k_r;
    end
    win_last_s = ~({CNT_W{1'b1}} << k_s);
    last_s     = (count_r == win_last_s);
    sum_s      = acc_r + {{MAX_LOG2{sample_s[SAMPLE_WIDTH-1]}}, sample_s};
    avg_wide_s = sum_s >>> k_s;
    load_s     = accept_s & last_s;
    if (pkt_r == PKT_LAST) begin
      pkt_next_s = '0;
    end else begin
      pkt_next_s = pkt_r + PKT_W'(1);
    end
    if (out_fire_s) begin
      load_idx_s = pkt_next_s;
    end else begin
      load_idx_s = pkt_r;
    end
  end

`ifdef AXIS_ADC_DECIM_STATUS_EN
  logic ovr_r;

  // Overrun flag: any stalled upstream word since the previous window completed belongs to this window
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ovr_r <= 1'b0;
    end else if (!enable || load_s) begin
      ovr_r <= 1'b0;
    end else if (s_axis_tvalid && !s_axis_tready) begin
      ovr_r <= 1'b1;
    end
  end

  assign status_s = LOW_W'({ovr_r, 3'b000, k_s});
`else
  assign status_s = '0;
`endif

  // Accumulator, sample count and latched window length
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc_r   <= '0;
      count_r <= '0;
      k_r     <= 4'd0;
    end else if (!enable) begin
      acc_r   <= '0;
      count_r <= '0;
    end else if (accept_s) begin
      if (count_r == '0) begin
        k_r <= k_req_s;
      end
      if (last_s) begin
        acc_r   <= '0;
        count_r <= '0;
      end else begin
        acc_r   <= sum_s;
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  // Output register: holds the word until the downstream handshake
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tdata_r  <= '0;
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
    end else if (load_s) begin
      tdata_r  <= {avg_wide_s[SAMPLE_WIDTH-1:0], status_s};
      tvalid_r <= 1'b1;
      tlast_r  <= (load_idx_s == PKT_LAST);
    end else if (out_fire_s) begin
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
    end
  end

  // Packet position counter, advanced per output handshake and untouched by enable
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_r <= '0;
    end else if (out_fire_s) begin
      pkt_r <= pkt_next_s;
    end
  end

endmodule
